// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchroniser, mid-bit 3-sample majority vote,
// parity/framing/break detection, first-word fall-through receive FIFO and RTS flow control.
module uart_rx_os #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int RTS_THRESH = FIFO_DEPTH - 2,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                          Clk,
    input  logic                          Rst_N,
    input  logic                          Rx_In,
    input  logic [DIV_WIDTH-1:0]          Baud_Div,
    input  logic [1:0]                    Cfg_Parity,
    input  logic                          Cfg_Stop2,
    output logic [DATA_BITS-1:0]          Rx_Data_Out,
    output logic [2:0]                    Rx_Error,
    output logic                          Data_Rdy_Out,
    input  logic                          Data_Ack_In,
    output logic                          Overrun,
    input  logic                          Overrun_Clr,
    output logic                          RTS,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count,
    output logic                          Busy
);

    localparam int OSW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_BITS);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int WW  = DATA_BITS + 3;
    localparam int M   = OVERSAMPLE / 2;

    localparam logic [OSW-1:0] OS_A    = OSW'(M - 1);
    localparam logic [OSW-1:0] OS_B    = OSW'(M);
    localparam logic [OSW-1:0] OS_C    = OSW'(M + 1);
    localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);
    localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]  RTS_CNT  = CW'(RTS_THRESH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        PUSH   = 3'd5
    } state_t;

    // Synchroniser and tick generator
    logic                 rx_s1, rx_s;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic                 tick;

    assign tick = (div_cnt == Baud_Div);

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            rx_s1   <= 1'b1;
            rx_s    <= 1'b1;
            div_cnt <= '0;
        end else begin
            rx_s1   <= Rx_In;
            rx_s    <= rx_s1;
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    // Frame FSM registers and their next values
    state_t               state, state_n;
    logic [OSW-1:0]       os, os_n;
    logic [BCW-1:0]       bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 s0, s0_n, s1, s1_n;
    logic                 par_bit, par_bit_n;
    logic                 ferr, ferr_n;
    logic                 armed, armed_n;
    logic                 par_en, par_en_n;
    logic                 odd, odd_n;
    logic                 stop2, stop2_n;
    logic                 push_req;
    logic                 vote, os_last, is_break, par_err;
    logic [WW-1:0]        push_word;

    assign vote     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign os_last  = (os == OS_LAST);
    assign is_break = (shreg == '0) && (!par_en || !par_bit) && ferr;
    assign par_err  = par_en && ((^shreg ^ par_bit) != odd);
    assign push_word = is_break ? {3'b101, {DATA_BITS{1'b0}}}
                                : {ferr, par_err, 1'b0, shreg};

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            state   <= IDLE;
            os      <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            s0      <= 1'b1;
            s1      <= 1'b1;
            par_bit <= 1'b0;
            ferr    <= 1'b0;
            armed   <= 1'b1;
            par_en  <= 1'b0;
            odd     <= 1'b0;
            stop2   <= 1'b0;
        end else begin
            state   <= state_n;
            os      <= os_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            s0      <= s0_n;
            s1      <= s1_n;
            par_bit <= par_bit_n;
            ferr    <= ferr_n;
            armed   <= armed_n;
            par_en  <= par_en_n;
            odd     <= odd_n;
            stop2   <= stop2_n;
        end
    end

    always_comb begin
        state_n   = state;
        os_n      = os;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        s0_n      = s0;
        s1_n      = s1;
        par_bit_n = par_bit;
        ferr_n    = ferr;
        armed_n   = armed;
        par_en_n  = par_en;
        odd_n     = odd;
        stop2_n   = stop2;
        push_req  = 1'b0;

        // Every in-frame state shares the per-bit tick counter and vote samples
        if (tick && (state != IDLE) && (state != PUSH)) begin
            if (os == OS_A) s0_n = rx_s;
            if (os == OS_B) s1_n = rx_s;
            os_n = os_last ? '0 : os + 1'b1;
        end

        case (state)
            IDLE: begin
                if (tick) begin
                    if (rx_s) begin
                        armed_n = 1'b1;
                    end else if (armed) begin
                        state_n   = START;
                        os_n      = '0;
                        bit_cnt_n = '0;
                        ferr_n    = 1'b0;
                        par_en_n  = (Cfg_Parity == 2'b01) || (Cfg_Parity == 2'b10);
                        odd_n     = (Cfg_Parity == 2'b10);
                        stop2_n   = Cfg_Stop2;
                    end
                end
            end
            START: begin
                if (tick) begin
                    if (os == OS_C && vote) begin
                        state_n = IDLE;
                    end else if (os_last) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (os == OS_C) begin
                        if (MSB_FIRST) shreg_n = {shreg[DATA_BITS-2:0], vote};
                        else           shreg_n = {vote, shreg[DATA_BITS-1:1]};
                    end
                    if (os_last) begin
                        if (bit_cnt == LAST_BIT) begin
                            state_n   = par_en ? PARITY : STOP;
                            bit_cnt_n = '0;
                        end else begin
                            bit_cnt_n = bit_cnt + 1'b1;
                        end
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    if (os == OS_C) par_bit_n = vote;
                    if (os_last) begin
                        state_n   = STOP;
                        bit_cnt_n = '0;
                    end
                end
            end
            STOP: begin
                // Leave mid-bit on the last stop bit so a back-to-back start edge is seen
                if (tick) begin
                    if (os == OS_C) begin
                        if (!vote) ferr_n = 1'b1;
                        if (bit_cnt == {{(BCW-1){1'b0}}, stop2}) state_n = PUSH;
                    end else if (os_last) begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            PUSH: begin
                push_req = 1'b1;
                state_n  = IDLE;
                if (is_break) armed_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    assign Busy = (state != IDLE);

    // Receive FIFO. Handshake: Data_Rdy_Out is valid, Data_Ack_In is ready; the head
    // word is consumed on any Clk edge where both are 1 and stays stable until then.
    logic [WW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic          pop, full, push_ok;

    assign full    = (cnt == FULL_CNT);
    assign pop     = (cnt != '0) && Data_Ack_In;
    assign push_ok = push_req && (!full || pop);

    always_ff @(posedge Clk) begin
        if (push_ok) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            Overrun <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (push_req && full && !pop) Overrun <= 1'b1;
            else if (Overrun_Clr)         Overrun <= 1'b0;
        end
    end

    assign Fifo_Count   = cnt;
    assign Data_Rdy_Out = (cnt != '0);
    assign RTS          = (cnt < RTS_CNT);
    assign Rx_Data_Out  = Data_Rdy_Out ? mem[rd_ptr][DATA_BITS-1:0] : '0;
    assign Rx_Error     = Data_Rdy_Out ? mem[rd_ptr][WW-1:DATA_BITS] : 3'b000;

endmodule
